// File: rtl/v_inst_issue_seq.sv
// v_inst_issue_seq: vector instruction issue sequencer.
//
// Takes one macro command per handshake and expands it into cmd_count_i
// encoded 32-bit vector instructions. The instructions go out on a valid/ready
// stream. The vd, vs1, vs2 and funct7 fields can each step by +1 on every
// issued instruction.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   cmd_valid_i/ready_o command handshake (ready only in IDLE)
//   cmd_class_i         0=load, 1=store, 2=arith, 3=illegal
//   cmd_funct7_i, cmd_funct3_i, cmd_vd_i, cmd_vs1_i, cmd_vs2_i
//                       initial instruction fields
//   cmd_count_i         number of instructions to emit
//   cmd_step_i          per-iteration +1 enables {funct7, vs2, vs1, vd}
//   inst_valid_o/ready_i, inst_o
//                       instruction stream
//   busy_o              high while issuing
//   done_o, err_o       one-cycle completion / illegal-class pulses
//   stall_cnt_o         backpressure cycle counter
//
// Build option: define V_ISSUE_PERF_CNT_EN to build the stall counter.
// When it is undefined, stall_cnt_o is tied to 0.
module v_inst_issue_seq #(
    parameter int unsigned INST_DW = 32,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned VREG_AW = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic [1:0]         cmd_class_i,
    input  logic [6:0]         cmd_funct7_i,
    input  logic [2:0]         cmd_funct3_i,
    input  logic [VREG_AW-1:0] cmd_vd_i,
    input  logic [VREG_AW-1:0] cmd_vs1_i,
    input  logic [VREG_AW-1:0] cmd_vs2_i,
    input  logic [CNT_W-1:0]   cmd_count_i,
    input  logic [3:0]         cmd_step_i,
    output logic               inst_valid_o,
    input  logic               inst_ready_i,
    output logic [INST_DW-1:0] inst_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o,
    output logic [31:0]        stall_cnt_o
);

    localparam logic StIdle  = 1'b0;
    localparam logic StIssue = 1'b1;

    localparam logic [6:0] OpLoad  = 7'b0000111;
    localparam logic [6:0] OpStore = 7'b0100111;
    localparam logic [6:0] OpArith = 7'b1010111;

    logic               state_q, state_d;
    logic [6:0]         opcode_q, opcode_d;
    logic [6:0]         funct7_q, funct7_d;
    logic [2:0]         funct3_q, funct3_d;
    logic [VREG_AW-1:0] vd_q, vd_d;
    logic [VREG_AW-1:0] vs1_q, vs1_d;
    logic [VREG_AW-1:0] vs2_q, vs2_d;
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic [3:0]         step_q, step_d;
    logic               valid_q, valid_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic cmd_accept;
    logic inst_fire;

    assign cmd_ready_o  = (state_q == StIdle);
    assign busy_o       = (state_q != StIdle);
    assign inst_valid_o = valid_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign inst_o       = {funct7_q, vs2_q, vs1_q, funct3_q, vd_q, opcode_q};

    assign cmd_accept = cmd_valid_i && cmd_ready_o;
    assign inst_fire  = valid_q && inst_ready_i;

    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        funct7_d    = funct7_q;
        funct3_d    = funct3_q;
        vd_d        = vd_q;
        vs1_d       = vs1_q;
        vs2_d       = vs2_q;
        remaining_d = remaining_q;
        step_d      = step_q;
        valid_d     = valid_q;
        done_d      = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            StIdle: begin
                if (cmd_accept) begin
                    funct7_d    = cmd_funct7_i;
                    funct3_d    = cmd_funct3_i;
                    vd_d        = cmd_vd_i;
                    vs1_d       = cmd_vs1_i;
                    vs2_d       = cmd_vs2_i;
                    remaining_d = cmd_count_i;
                    step_d      = cmd_step_i;
                    case (cmd_class_i)
                        2'd0:    opcode_d = OpLoad;
                        2'd1:    opcode_d = OpStore;
                        2'd2:    opcode_d = OpArith;
                        default: opcode_d = 7'd0;
                    endcase
                    if (cmd_class_i == 2'd3) begin
                        err_d  = 1'b1;
                        done_d = 1'b1;
                    end else if (cmd_count_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = StIssue;
                        valid_d = 1'b1;
                    end
                end
            end
            StIssue: begin
                if (inst_fire) begin
                    remaining_d = remaining_q - 1'b1;
                    // Fields wrap naturally at their register width.
                    if (step_q[0]) vd_d     = vd_q + 1'b1;
                    if (step_q[1]) vs1_d    = vs1_q + 1'b1;
                    if (step_q[2]) vs2_d    = vs2_q + 1'b1;
                    if (step_q[3]) funct7_d = funct7_q + 1'b1;
                    if (remaining_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                        state_d = StIdle;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            opcode_q    <= '0;
            funct7_q    <= '0;
            funct3_q    <= '0;
            vd_q        <= '0;
            vs1_q       <= '0;
            vs2_q       <= '0;
            remaining_q <= '0;
            step_q      <= '0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            opcode_q    <= opcode_d;
            funct7_q    <= funct7_d;
            funct3_q    <= funct3_d;
            vd_q        <= vd_d;
            vs1_q       <= vs1_d;
            vs2_q       <= vs2_d;
            remaining_q <= remaining_d;
            step_q      <= step_d;
            valid_q     <= valid_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

`ifdef V_ISSUE_PERF_CNT_EN
    logic [31:0] stall_q;

    // Clears on acceptance, saturates, and holds between commands.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
        end else if (cmd_accept) begin
            stall_q <= '0;
        end else if (valid_q && !inst_ready_i && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_q;
`else
    assign stall_cnt_o = 32'd0;
`endif

endmodule
